// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC, fetching over a req/ack bus with delay-slot branches and flush redirects.
// Optional misaligned-PC detection is enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_rom_ce,
  output logic        stallreq_if,
  output logic        if_excp_adel
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
  state_t      state;
  logic [31:0] pc, pend_target, hold_pc, hold_inst, disc_addr, next_pc, fetch_inst;
  logic        pend_vld, mis, ack, present, advance;
  logic        unused;
  assign unused = &{1'b0, stall[5:1]};
`ifdef IF_ALIGN_CHECK_EN
  assign mis          = pc[1:0] != 2'b00;
  assign ibus_addr_o  = state == DISCARD ? disc_addr : pc;
  assign if_excp_adel = if_rom_ce && if_pc[1:0] != 2'b00;
`else
  assign mis          = 1'b0;
  assign ibus_addr_o  = state == DISCARD ? disc_addr : {pc[31:2], 2'b00};
  assign if_excp_adel = 1'b0;
`endif
  // A misaligned PC completes locally as if acked, presenting a NOP
  assign ack         = state == FETCH && (mis || ibus_ack_i);
  assign fetch_inst  = mis ? 32'h0 : ibus_data_i;
  assign present     = ack || state == HOLD;
  assign advance     = present && !stall[0] && !flush_i;
  assign next_pc     = branch_flag_i ? branch_target_i : pend_vld ? pend_target : pc + 32'd4;
  assign ibus_req_o  = (state == FETCH && !mis) || state == DISCARD;
  assign if_rom_ce   = present && !flush_i;
  assign if_pc       = !if_rom_ce ? 32'h0 : state == HOLD ? hold_pc : pc;
  assign if_inst     = !if_rom_ce ? 32'h0 : state == HOLD ? hold_inst : fetch_inst;
  assign stallreq_if = (state == FETCH && !ack) || state == DISCARD;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_vld    <= 1'b0;
      pend_target <= 32'h0;
      hold_pc     <= 32'h0;
      hold_inst   <= 32'h0;
      disc_addr   <= 32'h0;
    end else if (flush_i && state != IDLE) begin
      pc       <= new_pc_i;
      pend_vld <= 1'b0;
      if (state == FETCH && !ack) begin
        state     <= DISCARD;
        disc_addr <= ibus_addr_o;
      end else if (state != DISCARD) state <= FETCH;
    end else begin
      if (branch_flag_i) begin
        pend_target <= branch_target_i;
        pend_vld    <= 1'b1;
      end
      if (state == IDLE) state <= FETCH;
      else if (advance) begin
        pc       <= next_pc;
        pend_vld <= 1'b0;
        state    <= FETCH;
      end else if (ack) begin
        hold_pc   <= pc;
        hold_inst <= fetch_inst;
        state     <= HOLD;
      end else if (state == DISCARD && ibus_ack_i) state <= FETCH;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus a randomized run checked against an instruction-stream model.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        ibus_req, ibus_ack = 1'b0;
  logic [31:0] ibus_addr, ibus_data = '0;
  logic [31:0] if_pc, if_inst;
  logic        if_rom_ce, stallreq_if, if_excp_adel;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_flag_i(branch_flag), .branch_target_i(branch_target),
    .flush_i(flush), .new_pc_i(new_pc),
    .ibus_req_o(ibus_req), .ibus_addr_o(ibus_addr),
    .ibus_ack_i(ibus_ack), .ibus_data_i(ibus_data),
    .if_pc(if_pc), .if_inst(if_inst), .if_rom_ce(if_rom_ce),
    .stallreq_if(stallreq_if), .if_excp_adel(if_excp_adel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lat_cfg = 0;
  logic rst_v = 1'b0;
  logic busy = 1'b0, moved = 1'b0;
  int cnt = 0;
  logic [31:0] a_lat = '0;
  logic        o_req, o_ce, o_stallreq, o_adel;
  logic [31:0] o_addr, o_pc, o_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  task automatic step(input logic st0, input logic br, input logic [31:0] bt,
                      input logic fl, input logic [31:0] np, input logic [4:0] hi);
    @(negedge clk);
    rst_n = rst_v;
    stall = {hi, st0};
    branch_flag = br;
    branch_target = bt;
    flush = fl;
    new_pc = np;
    moved = 1'b0;
    if (!rst_v) begin
      busy = 1'b0;
      ibus_ack = 1'b0;
    end else if (ibus_req === 1'b1) begin
      if (!busy) begin
        busy = 1'b1;
        cnt = lat_cfg < 0 ? int'($urandom_range(0, 2)) : lat_cfg;
        a_lat = ibus_addr;
      end else moved = ibus_addr !== a_lat;
      ibus_ack = cnt == 0;
      ibus_data = ibus_ack ? mem(ibus_addr) : $urandom;
    end else ibus_ack = 1'b0;
    #4;
    o_req = ibus_req; o_addr = ibus_addr; o_ce = if_rom_ce; o_pc = if_pc;
    o_inst = if_inst; o_stallreq = stallreq_if; o_adel = if_excp_adel;
    @(posedge clk);
    if (ibus_ack) busy = 1'b0;
    else if (busy) cnt--;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5'h0);
  endtask

  task automatic do_reset();
    lat_cfg = 0;
    rst_v = 1'b0;
    idle_step();
    idle_step();
    rst_v = 1'b1;
    idle_step();
  endtask

  task automatic test_reset();
    rst_v = 1'b0;
    idle_step();
    idle_step();
    checks++;
    if ({o_req, o_ce, o_stallreq, o_adel, o_pc, o_inst} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b ce=%b stallreq=%b adel=%b pc=%h inst=%h, want all zero", o_req, o_ce, o_stallreq, o_adel, o_pc, o_inst);
    end
    rst_v = 1'b1;
    idle_step();
    checks++;
    if ({o_req, o_ce, o_stallreq} !== 3'b000) begin
      failures++;
      $display("FAIL idle_cycle: req=%b ce=%b stallreq=%b, want 000", o_req, o_ce, o_stallreq);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle_step();
      checks++;
      if (o_ce !== 1'b1 || o_pc !== 32'(4 * i) || o_inst !== mem(32'(4 * i)) || o_stallreq !== 1'b0) begin
        failures++;
        $display("FAIL stream[%0d]: ce=%b pc=%h inst=%h stallreq=%b, want ce=1 pc=%h inst=%h stallreq=0", i, o_ce, o_pc, o_inst, o_stallreq, 4 * i, mem(32'(4 * i)));
      end
    end
  endtask

  task automatic test_wait();
    do_reset();
    idle_step();
    idle_step();
    lat_cfg = 3;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      checks++;
      if (o_stallreq !== 1'b1 || o_ce !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h8) begin
        failures++;
        $display("FAIL wait[%0d]: stallreq=%b ce=%b req=%b addr=%h, want 1 0 1 00000008", i, o_stallreq, o_ce, o_req, o_addr);
      end
    end
    idle_step();
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h8 || o_inst !== mem(32'h8) || o_stallreq !== 1'b0) begin
      failures++;
      $display("FAIL wait_done: ce=%b pc=%h inst=%h stallreq=%b, want 1 00000008 %h 0", o_ce, o_pc, o_inst, o_stallreq, mem(32'h8));
    end
  endtask

  task automatic test_hold();
    do_reset();
    idle_step();
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 5'h0);
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h4) begin
      failures++;
      $display("FAIL hold_ack: ce=%b pc=%h, want 1 00000004", o_ce, o_pc);
    end
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 1'b0, 32'h0, 1'b0, 32'h0, 5'h0);
      checks++;
      if (o_ce !== 1'b1 || o_pc !== 32'h4 || o_inst !== mem(32'h4) || o_req !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: ce=%b pc=%h inst=%h req=%b, want 1 00000004 %h 0", i, o_ce, o_pc, o_inst, o_req, mem(32'h4));
      end
    end
    idle_step();
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h8 || o_req !== 1'b1) begin
      failures++;
      $display("FAIL hold_resume: ce=%b pc=%h req=%b, want 1 00000008 1", o_ce, o_pc, o_req);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 4; i++) idle_step();
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 5'h0);
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h10) begin
      failures++;
      $display("FAIL branch_slot: ce=%b pc=%h, want 1 00000010", o_ce, o_pc);
    end
    idle_step();
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h100 || o_addr !== 32'h100 || o_inst !== mem(32'h100)) begin
      failures++;
      $display("FAIL branch_target: ce=%b pc=%h addr=%h inst=%h, want 1 00000100 00000100 %h", o_ce, o_pc, o_addr, o_inst, mem(32'h100));
    end
    lat_cfg = 2;
    step(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 5'h0);
    idle_step();
    idle_step();
    lat_cfg = 0;
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h104) begin
      failures++;
      $display("FAIL pend_slot: ce=%b pc=%h, want 1 00000104", o_ce, o_pc);
    end
    idle_step();
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h200) begin
      failures++;
      $display("FAIL pend_target: ce=%b pc=%h, want 1 00000200", o_ce, o_pc);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 8; i++) idle_step();
    lat_cfg = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h180, 5'h0);
    checks++;
    if (o_ce !== 1'b0 || o_addr !== 32'h20) begin
      failures++;
      $display("FAIL flush_cycle: ce=%b addr=%h, want 0 00000020", o_ce, o_addr);
    end
    lat_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      checks++;
      if (o_ce !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h20 || o_stallreq !== 1'b1) begin
        failures++;
        $display("FAIL discard[%0d]: ce=%b req=%b addr=%h stallreq=%b, want 0 1 00000020 1", i, o_ce, o_req, o_addr, o_stallreq);
      end
    end
    idle_step();
    checks++;
    if (o_ce !== 1'b1 || o_pc !== 32'h180 || o_addr !== 32'h180) begin
      failures++;
      $display("FAIL flush_target: ce=%b pc=%h addr=%h, want 1 00000180 00000180", o_ce, o_pc, o_addr);
    end
  endtask

`ifdef IF_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset();
    step(1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 5'h0);
    idle_step();
    checks++;
    if (o_req !== 1'b0 || o_adel !== 1'b1 || o_inst !== 32'h0 || o_pc !== 32'h102 || o_ce !== 1'b1) begin
      failures++;
      $display("FAIL align: req=%b adel=%b inst=%h pc=%h ce=%b, want 0 1 00000000 00000102 1", o_req, o_adel, o_inst, o_pc, o_ce);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_pc, ptgt, bt, np;
    logic        pend, st0, br, fl;
    int          delivered;
    do_reset();
    lat_cfg = -1;
    exp_pc = 32'h0;
    pend = 1'b0;
    ptgt = '0;
    delivered = 0;
    for (int c = 0; c < 1500; c++) begin
      st0 = $urandom_range(0, 3) == 0;
      br  = $urandom_range(0, 9) == 0;
      fl  = $urandom_range(0, 24) == 0;
      bt  = 32'($urandom_range(0, 1023)) << 2;
      np  = 32'($urandom_range(0, 1023)) << 2;
      step(st0, br, bt, fl, np, 5'($urandom));
      checks++;
      if (moved) begin
        failures++;
        $display("FAIL addr_stable: cycle %0d addr=%h, want %h", c, o_addr, a_lat);
      end
      if (fl) begin
        checks++;
        if (o_ce !== 1'b0) begin
          failures++;
          $display("FAIL rand_flush: cycle %0d ce=%b, want 0", c, o_ce);
        end
        exp_pc = np;
        pend = 1'b0;
      end else begin
        if (o_ce === 1'b1) begin
          checks++;
          if (o_pc !== exp_pc || o_inst !== mem(exp_pc) || o_stallreq !== 1'b0) begin
            failures++;
            $display("FAIL rand_deliver: cycle %0d pc=%h inst=%h stallreq=%b, want %h %h 0", c, o_pc, o_inst, o_stallreq, exp_pc, mem(exp_pc));
          end
        end
        if (o_ce === 1'b1 && !st0) begin
          exp_pc = br ? bt : pend ? ptgt : exp_pc + 32'd4;
          pend = 1'b0;
          delivered++;
        end else if (br) begin
          pend = 1'b1;
          ptgt = bt;
        end
      end
    end
    checks++;
    if (delivered < 100) begin
      failures++;
      $display("FAIL rand_progress: delivered=%0d, want >= 100", delivered);
    end
    lat_cfg = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_hold();
    test_branch();
    test_flush();
`ifdef IF_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
